// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the loadable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/seq_shift_matcher.sv
// Serial history shift register with fill counter; flags a pattern match on the
// completing bit so the caller can register the hit on the same edge.
module seq_shift_matcher
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             clr_fill,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] shifted_s;
  logic             fill_ok_s;

  // Only PAT_W-1 past bits are stored; the incoming bit completes the window.
  assign shifted_s = {hist_q, x};
  assign fill_ok_s = (fill_q >= FW'(PAT_W - 1));

  // Next-state for history and fill counter, plus the combinational match flag.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    match  = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      match  = fill_ok_s && (shifted_s == pattern);
      hist_d = shifted_s[PAT_W-2:0];
      if (clr_fill) begin
        fill_d = '0;
      end else if (fill_q != FW'(PAT_W)) begin
        fill_d = fill_q + FW'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      hist_d = hist_q;
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-control wrapper for a loadable serial pattern detector with hit threshold.
// Optional feature: define SEQ_DET_NONOVL_EN to honour cfg_nonovl (non-overlapping hits).
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_threshold,
  input  logic             cfg_nonovl,
  input  logic             start,
  input  logic             stop,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             done
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0] threshold_q, threshold_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             hit_q, hit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             shift_en_s;
  logic             clr_s;
  logic             clr_fill_s;
  logic             match_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

`ifdef SEQ_DET_NONOVL_EN
  logic nonovl_q, nonovl_d;
  assign clr_fill_s = match_s && nonovl_q;
`else
  logic unused_nonovl_s;
  assign unused_nonovl_s = cfg_nonovl;
  assign clr_fill_s      = 1'b0;
`endif

  seq_shift_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en_s),
    .clr      (clr_s),
    .clr_fill (clr_fill_s),
    .x        (x),
    .pattern  (pattern_q),
    .match    (match_s)
  );

  // Run-control FSM, config capture and hit counting.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    threshold_d = threshold_q;
    hit_count_d = hit_count_q;
    hit_d       = 1'b0;
    shift_en_s  = 1'b0;
    clr_s       = 1'b0;
`ifdef SEQ_DET_NONOVL_EN
    nonovl_d    = nonovl_q;
`endif
    case (state_q)
      IDLE: begin
        // A config handshake takes precedence over a coincident start.
        if (cfg_valid) begin
          pattern_d   = cfg_pattern;
          threshold_d = cfg_threshold;
`ifdef SEQ_DET_NONOVL_EN
          nonovl_d    = cfg_nonovl;
`endif
        end else if (start) begin
          state_d     = RUN;
          hit_count_d = '0;
          clr_s       = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        shift_en_s = x_valid;
        hit_d      = match_s;
        if (match_s) begin
          hit_count_d = sat_inc(hit_count_q);
        end else begin
          hit_count_d = hit_count_q;
        end
        if ((threshold_q != '0) && (hit_count_d == threshold_q)) begin
          state_d = DONE;
        end else if (stop) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (stop || cfg_valid) begin
          state_d = IDLE;
        end else if (start) begin
          state_d     = RUN;
          hit_count_d = '0;
          clr_s       = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cfg_ready_d = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    done_d      = (state_d == DONE);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      threshold_q <= '0;
      hit_count_q <= '0;
      hit_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
`ifdef SEQ_DET_NONOVL_EN
      nonovl_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      threshold_q <= threshold_d;
      hit_count_q <= hit_count_d;
      hit_q       <= hit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_ready_q <= cfg_ready_d;
`ifdef SEQ_DET_NONOVL_EN
      nonovl_q    <= nonovl_d;
`endif
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign hit       = hit_q;
  assign hit_count = hit_count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Table-driven, scoreboarded bench for seq_detect_ctrl; expectations follow SEQ_DET_NONOVL_EN.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_pattern = 4'd0;
  logic [7:0] cfg_threshold = 8'd0;
  logic       cfg_nonovl = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       busy;
  logic       hit;
  logic [7:0] hit_count;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SEQ_DET_NONOVL_EN
  localparam bit NONOVL = 1'b1;
`else
  localparam bit NONOVL = 1'b0;
`endif

  seq_detect_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_pattern   (cfg_pattern),
    .cfg_threshold (cfg_threshold),
    .cfg_nonovl    (cfg_nonovl),
    .start         (start),
    .stop          (stop),
    .x             (x),
    .x_valid       (x_valid),
    .busy          (busy),
    .hit           (hit),
    .hit_count     (hit_count),
    .done          (done)
  );

  always #5 clk = ~clk;

  // exp packs {hit, busy, done, cfg_ready, hit_count}
  typedef struct {
    logic       cv;
    logic [3:0] pat;
    logic [7:0] thr;
    logic       nv;
    logic       st;
    logic       sp;
    logic       xb;
    logic       xv;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    int          idx;
    logic [11:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  function automatic logic [11:0] e(input logic h, input logic b, input logic d,
                                    input logic r, input logic [7:0] c);
    return {h, b, d, r, c};
  endfunction

  task automatic add(input logic cv, input logic [3:0] pat, input logic [7:0] thr,
                     input logic nv, input logic st, input logic sp, input logic xb,
                     input logic xv, input logic [11:0] ex);
    vec_t v;
    v.cv = cv; v.pat = pat; v.thr = thr; v.nv = nv;
    v.st = st; v.sp = sp; v.xb = xb; v.xv = xv; v.exp = ex;
    vecs.push_back(v);
  endtask

  // Shorthand: a data-only cycle in RUN or DONE.
  task automatic bitv(input logic xb, input logic xv, input logic [11:0] ex);
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, xb, xv, ex);
  endtask

  task automatic chk(input string name, input logic [11:0] ex);
    logic [11:0] act;
    act = {hit, busy, done, cfg_ready, hit_count};
    n_tests++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got hit=%b busy=%b done=%b rdy=%b cnt=%0d, want hit=%b busy=%b done=%b rdy=%b cnt=%0d",
               name, act[11], act[10], act[9], act[8], act[7:0],
               ex[11], ex[10], ex[9], ex[8], ex[7:0]);
    end
  endtask

  task automatic drive_idle();
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] cnt;
    logic       eh;
    logic [3:0] p1010;
    p1010 = 4'b1010;

    // 1: overlap, threshold 0
    add(1'b1, p1010, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd0));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b1,1'b1,1'b0,1'b0,8'd1));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd1));
    bitv(1'b0, 1'b1, e(1'b1,1'b1,1'b0,1'b0,8'd2));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd2));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd2));

    // 2: threshold 2 reaches DONE; cfg in DONE returns to IDLE without latching
    add(1'b1, p1010, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd2));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b1,1'b1,1'b0,1'b0,8'd1));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd1));
    bitv(1'b0, 1'b1, e(1'b1,1'b0,1'b1,1'b0,8'd2));
    bitv(1'b1, 1'b1, e(1'b0,1'b0,1'b1,1'b0,8'd2));
    add(1'b1, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd2));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b1,1'b1,1'b0,1'b0,8'd1));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd1));

    // threshold reached together with stop: DONE wins
    add(1'b1, p1010, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd1));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e(1'b1,1'b0,1'b1,1'b0,8'd1));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd1));

    // 4: x_valid gaps and cfg_valid during RUN
    add(1'b1, p1010, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd1));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    add(1'b1, 4'b1111, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b1,1'b1,1'b0,1'b0,8'd1));
    bitv(1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd1));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd1));

    // 5: stop coincident with completing bit, then restart clears count
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b0, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    bitv(1'b1, 1'b1, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e(1'b1,1'b0,1'b0,1'b1,8'd1));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd1));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd0));

    // 3: cfg_nonovl=1 on 1010101010; hits depend on whether the feature is built in
    add(1'b1, p1010, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,8'd0));
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e(1'b0,1'b1,1'b0,1'b0,8'd0));
    cnt = 8'd0;
    for (int i = 1; i <= 10; i++) begin
      if (NONOVL) eh = (i == 4) || (i == 8);
      else        eh = (i % 2 == 0) && (i >= 4);
      if (eh) cnt = cnt + 8'd1;
      bitv((i % 2) == 1, 1'b1, e(eh, 1'b1, 1'b0, 1'b0, cnt));
    end
    add(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e(1'b0,1'b0,1'b0,1'b1,cnt));

    // reset values while rst is held
    drive_idle();
    repeat (2) @(posedge clk);
    #1 chk("reset", e(1'b0,1'b0,1'b0,1'b1,8'd0));
    @(negedge clk);
    rst = 1'b0;

    // apply table; scoreboard carries expectations from drive to check
    for (int i = 0; i < vecs.size(); i++) begin
      sb_t s;
      @(negedge clk);
      cfg_valid = vecs[i].cv; cfg_pattern = vecs[i].pat; cfg_threshold = vecs[i].thr;
      cfg_nonovl = vecs[i].nv; start = vecs[i].st; stop = vecs[i].sp;
      x = vecs[i].xb; x_valid = vecs[i].xv;
      s.idx = i; s.exp = vecs[i].exp;
      sb_q.push_back(s);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: got 0 entries, want 1");
      end else begin
        s = sb_q.pop_front();
        chk($sformatf("vec%0d", s.idx), s.exp);
      end
    end
    @(negedge clk);
    drive_idle();

    // 6: rst mid-pattern after 101, with the completing bit in flight
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; x = 1'b1; x_valid = 1'b1;
    @(negedge clk); x = 1'b0;
    @(negedge clk); x = 1'b1;
    @(negedge clk); x = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_async", e(1'b0,1'b0,1'b0,1'b1,8'd0));
    @(posedge clk);
    #1 chk("rst_held", e(1'b0,1'b0,1'b0,1'b1,8'd0));
    @(negedge clk);
    rst = 1'b0; x_valid = 1'b0;
    @(posedge clk);
    #1 chk("rst_release", e(1'b0,1'b0,1'b0,1'b1,8'd0));
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    #1 chk("rst_restart", e(1'b0,1'b1,1'b0,1'b0,8'd0));
    @(negedge clk); start = 1'b0; x = 1'b0; x_valid = 1'b1;
    @(posedge clk);
    #1 chk("rst_nohit", e(1'b0,1'b1,1'b0,1'b0,8'd0));
    @(negedge clk); drive_idle(); stop = 1'b1;
    @(posedge clk);
    #1 chk("rst_stop", e(1'b0,1'b0,1'b0,1'b1,8'd0));
    @(negedge clk); stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
